// File: rtl/hex_share_ctrl_pkg.sv
// Shared definitions for the two-requester hex display arbiter.
package hex_share_ctrl_pkg;

    // Controller state: idle, or holding a value captured from A or B
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHOW_A = 2'd1,
        SHOW_B = 2'd2
    } state_t;

    // Requester identity, used to remember who was served last
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // All segments off on an active-low display
    localparam logic [6:0] HEX_BLANK = 7'b1111111;

endpackage

// File: rtl/hex7seg.sv
// Active-low seven-segment decoder: seg[0]=a through seg[6]=g.
module hex7seg (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Standard hex glyphs: 0-9, A, b, C, d, E, F
    always_comb begin
        seg = 7'b1111111;
        case (digit)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/hex_share_ctrl.sv
// Arbitrates a single seven-segment display between two requesters.
// Each granted digit is held for HOLD_CYCLES cycles; ties alternate.
module hex_share_ctrl
    import hex_share_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       ReqA,
    input  logic [3:0] ValA,
    input  logic       ReqB,
    input  logic [3:0] ValB,
    output logic       GntA,
    output logic       GntB,
    output logic       Busy,
    output logic [6:0] HEX
);

    // Counter just wide enough for HOLD_CYCLES-1 (at least one bit)
    localparam int              CNT_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    req_id_t          last_served;
    logic [3:0]       shown;
    logic [CNT_W-1:0] count;
    logic             decide;
    logic             win_a;
    logic             win_b;
    logic [6:0]       seg;

    // Decision edges happen in IDLE and on hold expiry; a tie goes to whoever was not served last
    always_comb begin
        decide = (state == IDLE) || (count == '0);
        win_a  = ReqA && (!ReqB || (last_served == REQ_B));
        win_b  = ReqB && (!ReqA || (last_served == REQ_A));
    end

    // Arbitration FSM with hold counter, captured digit and registered grant pulses
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state       <= IDLE;
            last_served <= REQ_B;
            shown       <= 4'h0;
            count       <= '0;
            GntA        <= 1'b0;
            GntB        <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            GntA <= 1'b0;
            GntB <= 1'b0;
            if (decide) begin
                if (win_a) begin
                    state       <= SHOW_A;
                    shown       <= ValA;
                    last_served <= REQ_A;
                    count       <= CNT_LOAD;
                    GntA        <= 1'b1;
                    Busy        <= 1'b1;
                end else if (win_b) begin
                    state       <= SHOW_B;
                    shown       <= ValB;
                    last_served <= REQ_B;
                    count       <= CNT_LOAD;
                    GntB        <= 1'b1;
                    Busy        <= 1'b1;
                end else begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

    hex7seg u_hex7seg (
        .digit (shown),
        .seg   (seg)
    );

    // Display is blank whenever nothing is being held
    always_comb begin
        HEX = (state == IDLE) ? HEX_BLANK : seg;
    end

endmodule
